// File: rtl/inference_sequencer.sv
// Sequences one inference frame through NUM_STAGES pipeline stages with a per-stage watchdog.
// Latency: start -> stage_start[0] is 1 cycle; stage_done[i] -> stage_start[i+1] or done is 1 cycle.
// Backpressure: start is ignored while busy; abort returns to IDLE; a stalled stage raises a sticky err.
module inference_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int FC_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic [1:0]            buf_owner,
    output logic [1:0]            cur_stage,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [FC_WIDTH-1:0]   frame_count
);

    localparam int IW = (NUM_STAGES > 4) ? $clog2(NUM_STAGES) : 2;
    localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t                state_q;
    logic [IW-1:0]         idx_q;
    logic [WW-1:0]         wd_q;
    logic [NUM_STAGES-1:0] stage_start_q;
    logic [1:0]            buf_owner_q;
    logic [1:0]            cur_stage_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [FC_WIDTH-1:0]   frame_count_q;

    logic [IW-1:0]         nxt_idx;
    logic                  cur_done;
    logic                  last_stage;
    logic                  wd_expired;

    assign nxt_idx    = idx_q + 1'b1;
    assign cur_done   = stage_done[idx_q];
    assign last_stage = (idx_q == IW'(NUM_STAGES - 1));
    assign wd_expired = (wd_q == WW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            wd_q          <= '0;
            stage_start_q <= '0;
            buf_owner_q   <= 2'd3;
            cur_stage_q   <= 2'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            frame_count_q <= '0;
        end else begin
            // Launch and completion strobes are single-cycle by default.
            stage_start_q <= '0;
            done_q        <= 1'b0;
            case (state_q)
                S_IDLE, S_ERROR: begin
                    if (start) begin
                        state_q       <= S_LAUNCH;
                        idx_q         <= '0;
                        wd_q          <= '0;
                        err_q         <= 1'b0;
                        stage_start_q <= {{(NUM_STAGES-1){1'b0}}, 1'b1};
                        buf_owner_q   <= 2'd0;
                        cur_stage_q   <= 2'd0;
                        busy_q        <= 1'b1;
                    end
                end
                S_LAUNCH: begin
                    if (abort) begin
                        state_q     <= S_IDLE;
                        buf_owner_q <= 2'd3;
                        busy_q      <= 1'b0;
                    end else begin
                        state_q <= S_WAIT;
                        wd_q    <= '0;
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        state_q     <= S_IDLE;
                        buf_owner_q <= 2'd3;
                        busy_q      <= 1'b0;
                    end else if (cur_done) begin
                        if (last_stage) begin
                            state_q       <= S_FINISH;
                            done_q        <= 1'b1;
                            frame_count_q <= frame_count_q + 1'b1;
                            buf_owner_q   <= 2'd3;
                        end else begin
                            state_q       <= S_LAUNCH;
                            idx_q         <= nxt_idx;
                            stage_start_q <= {{(NUM_STAGES-1){1'b0}}, 1'b1} << nxt_idx;
                            buf_owner_q   <= (nxt_idx <= IW'(2)) ? nxt_idx[1:0] : 2'd3;
                            cur_stage_q   <= nxt_idx[1:0];
                        end
                    end else if (wd_expired) begin
                        // idx and cur_stage are held so the stalled stage stays visible.
                        state_q     <= S_ERROR;
                        err_q       <= 1'b1;
                        buf_owner_q <= 2'd3;
                        busy_q      <= 1'b0;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_FINISH: begin
                    state_q     <= S_IDLE;
                    buf_owner_q <= 2'd3;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    buf_owner_q <= 2'd3;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign stage_start = stage_start_q;
    assign buf_owner   = buf_owner_q;
    assign cur_stage   = cur_stage_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed bench for inference_sequencer: nominal frame, timeout, spurious/boundary done, abort, wrap, reset.
module tb_inference_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [3:0] stage_done;
    logic [3:0] stage_start;
    logic [1:0] buf_owner;
    logic [1:0] cur_stage;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] frame_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_frames = 0;

    inference_sequencer #(
        .NUM_STAGES    (4),
        .TIMEOUT_CYCLES(16),
        .FC_WIDTH      (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .stage_done (stage_done),
        .stage_start(stage_start),
        .buf_owner  (buf_owner),
        .cur_stage  (cur_stage),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive inputs for one cycle, then observe the outputs of the following cycle.
    task automatic step(input logic s, input logic a, input logic [3:0] d);
        start      = s;
        abort      = a;
        stage_done = d;
        @(posedge clk);
        #1;
        start      = 1'b0;
        abort      = 1'b0;
        stage_done = 4'b0;
    endtask

    task automatic run_frame();
        logic [3:0] d;
        step(1'b1, 1'b0, 4'b0);
        check("frm_launch0", stage_start, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 4'b0);
            check("frm_busy_start", {busy, stage_start}, 5'b10000);
            d = 4'b0001 << k;
            step(1'b0, 1'b0, d);
            if (k < 3) check("frm_launch", stage_start, 4'b0010 << k);
            else       check("frm_done", done, 1'b1);
        end
        exp_frames++;
        check("frm_count", frame_count, exp_frames % 16);
        step(1'b1, 1'b0, 4'b0);
        check("frm_idle", {busy, done, stage_start}, 6'b0);
    endtask

    initial begin
        logic [3:0] d;
        logic [3:0] exp_ss;
        int         n;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        stage_done = 4'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_ss", stage_start, 4'b0);
        check("rst_owner", buf_owner, 2'd3);
        check("rst_misc", {cur_stage, busy, done, err}, 5'b0);
        check("rst_fc", frame_count, 4'd0);

        // Nominal: each stage done 5 cycles after its launch.
        for (int c = 0; c < 28; c++) begin
            d = 4'b0;
            if (c >= 6 && c <= 24 && (c % 6) == 0) d = 4'b0001 << (c / 6 - 1);
            step(c == 0, 1'b0, d);
            n = c + 1;
            exp_ss = 4'b0;
            if ((n % 6) == 1 && n <= 19) exp_ss = 4'b0001 << (n / 6);
            check("nom_ss", stage_start, exp_ss);
            check("nom_done", done, n == 25);
            check("nom_busy", busy, n >= 1 && n <= 25);
            check("nom_owner", buf_owner, (n >= 1 && n <= 18) ? (n - 1) / 6 : 3);
            check("nom_cur", cur_stage, (n >= 19) ? 3 : (n - 1) / 6);
        end
        exp_frames = 1;
        check("nom_fc", frame_count, 4'd1);

        // Timeout on stage 1.
        step(1'b1, 1'b0, 4'b0);
        step(1'b0, 1'b0, 4'b0);
        step(1'b0, 1'b0, 4'b0001);
        check("to_launch1", stage_start, 4'b0010);
        check("to_owner1", buf_owner, 2'd1);
        repeat (16) step(1'b0, 1'b0, 4'b0);
        check("to_pre", {busy, err}, 2'b10);
        step(1'b0, 1'b0, 4'b0);
        check("to_err", err, 1'b1);
        check("to_busy", busy, 1'b0);
        check("to_cur", cur_stage, 2'd1);
        check("to_owner", buf_owner, 2'd3);
        step(1'b0, 1'b1, 4'b0);
        check("to_abort_err", {err, busy}, 2'b10);
        step(1'b1, 1'b1, 4'b0);
        check("to_restart_ss", stage_start, 4'b0001);
        check("to_restart", {err, busy, cur_stage}, 4'b0100);
        step(1'b0, 1'b1, 4'b0);
        check("to_abort_launch", {busy, stage_start, buf_owner}, 7'b0000011);

        // Spurious / boundary done, then done coincident with timeout.
        step(1'b1, 1'b0, 4'b0);
        step(1'b0, 1'b0, 4'b0001);
        check("bd_launch_done", {busy, stage_start}, 5'b10000);
        step(1'b0, 1'b0, 4'b1000);
        check("bd_spurious", {stage_start, buf_owner, cur_stage}, 8'b0);
        step(1'b0, 1'b0, 4'b0001);
        check("bd_adv1", stage_start, 4'b0010);
        repeat (16) step(1'b0, 1'b0, 4'b0);
        check("bd_pre", {busy, err}, 2'b10);
        step(1'b0, 1'b0, 4'b0010);
        check("bd_tie_ss", stage_start, 4'b0100);
        check("bd_tie_err", {busy, err}, 2'b10);

        // Abort in third WAIT cycle of stage 2, together with its done.
        repeat (3) step(1'b0, 1'b0, 4'b0);
        step(1'b0, 1'b1, 4'b0100);
        check("ab_idle", {busy, done, stage_start}, 6'b0);
        check("ab_owner", buf_owner, 2'd3);
        check("ab_fc", frame_count, exp_frames % 16);
        step(1'b0, 1'b0, 4'b0100);
        check("ab_late_done", {busy, done, stage_start}, 6'b0);
        check("ab_fc2", frame_count, exp_frames % 16);

        // Busy starts ignored; frame counter wraps.
        for (int f = 0; f < 16; f++) run_frame();

        // Reset mid-WAIT of stage 1.
        step(1'b1, 1'b0, 4'b0);
        step(1'b0, 1'b0, 4'b0);
        step(1'b0, 1'b0, 4'b0001);
        step(1'b0, 1'b0, 4'b0);
        check("rm_pre", {busy, cur_stage}, 3'b101);
        reset = 1'b1;
        stage_done = 4'b0010;
        start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        stage_done = 4'b0;
        start = 1'b0;
        check("rm_ss", {stage_start, done}, 5'b0);
        check("rm_outs", {buf_owner, cur_stage, busy, err}, 6'b110000);
        check("rm_fc", frame_count, 4'd0);
        step(1'b1, 1'b0, 4'b0);
        check("rm_restart", {stage_start, cur_stage, buf_owner}, 8'b00010000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
